md_unit: RTL
============

# md_unit

Parametrised multiply/divide unit for the pipelined MIPS core, sitting beside the E-stage ALU and owning the HI/LO register pair. It accepts one operation per start pulse and holds results in HI/LO. Multiply and divide have independently configurable multi-cycle latencies, signalled through a busy flag that the stall unit consumes. The block generalises the single-cycle ALU path to variable width and latency, and adds an optional multiply-accumulate mode.

## Interface
- WIDTH, 32: operand and HI/LO width; must be an even number ≥ 8.
- MUL_LAT, 5: cycles from start to HI/LO update for multiply-class ops; must be ≥ 1.
- DIV_LAT, 10: cycles from start to HI/LO update for divide ops; must be ≥ 1.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low; 0 at a rising edge resets the block.
- start  in  1  one-cycle request strobe from the E stage.
- op  in  4  operation code, sampled only when start=1.
- rs_val  in  WIDTH  operand A (forwarded E_RS).
- rt_val  in  WIDTH  operand B (forwarded E_RT).
- busy  out  1  operation in flight.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- Op codes:
  - MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MADD=6, MADDU=7, MSUB=8, MSUBU=9.
  - Any other code is a no-op.
- States: IDLE, RUN.
  - IDLE→RUN: at an edge with start=1 and a multiply- or divide-class op. Operands and op are latched, the counter is loaded with MUL_LAT or DIV_LAT, and busy=1.
  - RUN: the counter decrements each edge.
  - RUN→IDLE: at the edge where the counter equals 1. HI/LO are written and busy=0.
- MTHI/MTLO: in IDLE, an edge with start=1 writes rs_val to hi/lo directly. busy is never raised.
- start=1 while busy=1 is ignored entirely; state, counter and HI/LO are unaffected.
- Multiply: the full 2·WIDTH-bit product; {hi,lo} = product. Signed for MULT, unsigned for MULTU.
- Divide:
  - lo = quotient, truncated toward zero; hi = remainder, carrying the sign of the dividend.
  - Divide by zero: the op runs the full DIV_LAT cycles, then leaves HI/LO unchanged.
  - Signed overflow (most-negative value ÷ −1): lo = most-negative value, hi = 0.
- MADD/MSUB: {hi,lo} ± product, modulo 2^(2·WIDTH). The HI/LO value used is the one held at the writeback edge.
- Reset:
  - hi=0, lo=0, busy=0, state IDLE, counter 0.
  - Reset during RUN aborts the op with no writeback. Reset dominates start.

## Timing
- Start sampled at edge 0 → busy=1 from edge 0 through edge LAT; HI/LO are visible in the cycle after edge LAT.
- busy is registered, with no combinational path from start.
- The stall unit must stall a D-stage md-class instruction (mult/div/mfhi/mflo/mthi/mtlo/madd/msub) while (E-stage start) or busy is high.
- MTHI/MTLO results are visible one cycle after the start edge.
- Back-to-back: a new start is accepted in the first cycle where busy=0, i.e. the cycle after edge LAT.

## Configuration
- MD_UNIT_MADD_EN defined: ops 6–9 are implemented as above.
- Not defined: codes 6–9 are no-ops. No state changes, busy stays 0, and the accumulate adder is absent.

## Structure
- Shared constants header (same file as the existing ALU/WD-select codes): md op codes, plus an `md_class` predicate for the stall unit.
- One sub-module, md_div: a combinational signed/unsigned quotient/remainder over WIDTH. It owns the divide-by-zero flag and the overflow special case.
- The multiply path, counter and HI/LO registers live in md_unit.

## Test plan
- MULT, rs=0xFFFFFFFE (−2), rt=3, MUL_LAT=5 → busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV, rs=−7 (0xFFFFFFF9), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles. DIV 0x80000000 by 0xFFFFFFFF → lo=0x80000000, hi=0. DIVU by 0 → HI/LO unchanged, busy still high for 10 cycles.
- MTHI 0x12345678, then MTLO 0x9 on consecutive cycles → hi=0x12345678, lo=9 with busy=0 throughout. A MULT start while busy → ignored, and the original result is intact.
- Reset pulled low in cycle 3 of a DIV → busy=0, hi=lo=0 next cycle, and no later writeback.
- With MD_UNIT_MADD_EN: hi=0, lo=0xFFFFFFFF, then MADDU 1×1 → hi=1, lo=0. MSUB 2×3 from zero → hi=0xFFFFFFFF, lo=0xFFFFFFFA. Without the macro → op 6 leaves busy=0 and HI/LO unchanged.

Source files
------------

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: md op codes and class predicates; MD_UNIT_MADD_EN adds the accumulate ops.
package md_unit_pkg;
  typedef enum logic [3:0] {
    MD_MULT  = 4'd0,
    MD_MULTU = 4'd1,
    MD_DIV   = 4'd2,
    MD_DIVU  = 4'd3,
    MD_MTHI  = 4'd4,
    MD_MTLO  = 4'd5,
    MD_MADD  = 4'd6,
    MD_MADDU = 4'd7,
    MD_MSUB  = 4'd8,
    MD_MSUBU = 4'd9
  } md_op_e;
  function automatic logic is_mul(input logic [3:0] op);
`ifdef MD_UNIT_MADD_EN
    return op == MD_MULT || op == MD_MULTU || (op >= MD_MADD && op <= MD_MSUBU);
`else
    return op == MD_MULT || op == MD_MULTU;
`endif
  endfunction
  function automatic logic is_div(input logic [3:0] op);
    return op == MD_DIV || op == MD_DIVU;
  endfunction
  // True for every op that occupies the unit; the stall unit holds D-stage md ops on it.
  function automatic logic md_class(input logic [3:0] op);
    return is_mul(op) || is_div(op) || op == MD_MTHI || op == MD_MTLO;
  endfunction
endpackage

// File: rtl/md_unit_div.sv
// md_div: combinational signed/unsigned divide with divide-by-zero flag and overflow case.
module md_div #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz
);
  logic na, nb, ov;
  logic [WIDTH-1:0] ua, ub, uq, ur;
  assign dz = b == '0;
  assign na = sgn & a[WIDTH-1];
  assign nb = sgn & b[WIDTH-1];
  assign ua = na ? -a : a;
  assign ub = dz ? WIDTH'(1) : nb ? -b : b;
  assign uq = ua / ub;
  assign ur = ua % ub;
  assign ov = sgn && a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1;
  assign q = ov ? {1'b1, {(WIDTH-1){1'b0}}} : (na ^ nb) ? -uq : uq;
  assign r = ov ? '0 : na ? -ur : ur;
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning HI/LO; MD_UNIT_MADD_EN enables MADD/MSUB.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2((MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT) + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [3:0] op_q;
  logic [WIDTH-1:0] a, b, q, r;
  logic [2*WIDTH-1:0] ax, bx, prod, mres;
  logic sgn, dz;
  // Even op codes of every multi-cycle class are the signed variants.
  assign sgn = ~op_q[0];
  assign ax = {{WIDTH{sgn & a[WIDTH-1]}}, a};
  assign bx = {{WIDTH{sgn & b[WIDTH-1]}}, b};
  assign prod = ax * bx;
`ifdef MD_UNIT_MADD_EN
  assign mres = (op_q == MD_MADD || op_q == MD_MADDU) ? {hi, lo} + prod :
                (op_q == MD_MSUB || op_q == MD_MSUBU) ? {hi, lo} - prod : prod;
`else
  assign mres = prod;
`endif
  md_div #(.WIDTH(WIDTH)) u_div (.a(a), .b(b), .sgn(sgn), .q(q), .r(r), .dz(dz));
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      op_q  <= '0;
      a     <= '0;
      b     <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (state == IDLE) begin
      if (start && (is_mul(op) || is_div(op))) begin
        state <= RUN;
        busy  <= 1'b1;
        op_q  <= op;
        a     <= rs_val;
        b     <= rt_val;
        cnt   <= is_div(op) ? CW'(DIV_LAT) : CW'(MUL_LAT);
      end else if (start && op == MD_MTHI) begin
        hi <= rs_val;
      end else if (start && op == MD_MTLO) begin
        lo <= rs_val;
      end
    end else begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        state <= IDLE;
        busy  <= 1'b0;
        if (!is_div(op_q)) {hi, lo} <= mres;
        else if (!dz) {hi, lo} <= {r, q};
      end
    end
  end
endmodule
